bram_thres_cfg_ctrl: RTL and testbench
======================================

Name: bram_thres_cfg_ctrl

Overview:
Host-side configuration sequencer for the per-channel parameter BRAM. The parameter BRAM holds five banks of DEPTH words: threshold, channel hash, offset, group number and reference channel. This block accepts single-word write, single-word read and bank-fill commands over a valid/ready command channel. It drives the BRAM's addr/we/re/din port, accounts for the BRAM's 1-cycle registered read, and returns exactly one response per command over a valid/ready response channel. The BRAM's streaming lookup ports are not touched by this block.

Parameters:
BITWIDTH, 32, data word width
DEPTH, 256, words per bank (channels)
BANK_NUM, 5, number of banks; legal address space is 0 .. BANK_NUM*DEPTH-1
ADDR_W, 16, BRAM address width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 write, 01 read, 10 fill bank, 11 reserved
cmd_addr  in  ADDR_W  word address (for fill: any address inside the target bank)
cmd_data  in  BITWIDTH  write data / fill value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  BITWIDTH  read data; 0 for write; DEPTH for fill; 0 on error
rsp_err  out  1  command rejected (bad address or reserved op)
busy  out  1  state != IDLE
err_cnt  out  16  saturating count of rejected commands
mem_addr  out  ADDR_W  to BRAM addr
mem_din  out  BITWIDTH  to BRAM din
mem_we  out  1  to BRAM we
mem_re  out  1  to BRAM re
mem_dout  in  BITWIDTH  from BRAM dout (valid the cycle after mem_re)

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0 except cmd_ready=1. err_cnt=0.
- All mem_* and rsp_* outputs are flop outputs.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid & cmd_ready. cmd_valid while not ready is ignored; no queueing.
- States: IDLE, WR, RD, RD_WAIT, FILL, RSP.
- Validation at accept:
  - op=11, or addr >= BANK_NUM*DEPTH: go to RSP with rsp_err=1, rsp_data=0. err_cnt increments, saturating at 16'hFFFF. No BRAM access occurs.
- Write: IDLE->WR. In the WR cycle: mem_we=1, mem_addr=cmd_addr, mem_din=cmd_data, for exactly 1 cycle. Then ->RSP with rsp_data=0, rsp_err=0.
- Read: IDLE->RD. In the RD cycle: mem_re=1, mem_addr=cmd_addr. RD->RD_WAIT. mem_dout is sampled at the end of RD_WAIT into rsp_data. ->RSP.
  - Latency from accept edge to rsp_valid high: 3 cycles.
- Fill: bank = cmd_addr / DEPTH. IDLE->FILL. For DEPTH consecutive cycles: mem_we=1, mem_din=cmd_data, mem_addr=bank*DEPTH+i for i=0..DEPTH-1.
  - The index counter has log2(DEPTH)+1 bits; terminal condition is i==DEPTH-1.
  - Then ->RSP with rsp_data=DEPTH, rsp_err=0.
  - mem_we is low the cycle after the last fill write.
- mem_we and mem_re are never high in the same cycle. Both are 0 in IDLE and RSP.
- RSP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid & rsp_ready; then ->IDLE with rsp_valid=0.
  - rsp_ready may already be high on entry; the handshake then completes in the first RSP cycle.
  - The next command can be accepted no earlier than the cycle after the response handshake.
- Reset mid-operation (any state): immediate return to reset values. A partially completed fill leaves the already-written words in the BRAM. No response is emitted for the interrupted command.
- Boundary addresses: addr = BANK_NUM*DEPTH-1 is legal; addr = BANK_NUM*DEPTH is an error. A fill with cmd_addr inside bank 4 writes 1024..1279.

Test Plan:
- Write cmd addr=3 data=32'hFFFF_FE0C, then read addr=3 -> mem_we pulses 1 cycle at addr 3; read response arrives 3 cycles after accept with rsp_data=32'hFFFF_FE0C, rsp_err=0.
- Fill op, addr=300, data=7 -> mem_we high for exactly 256 cycles at addr 256..511; rsp_data=256. Subsequent reads of 256 and 511 return 7.
- Read addr=1280, then op=11 -> two responses with rsp_err=1 and rsp_data=0; no mem_we or mem_re activity; err_cnt=2.
- rsp_ready held low 10 cycles after a read of addr=1279 -> rsp_valid stays 1 with data stable; cmd_ready=0 throughout; cmd_valid pulses are ignored.
- rst_n asserted at fill index 100 (bank 0, data 5) -> outputs return to reset values asynchronously; after release, cmd_ready=1; read addr=99 returns 5 and read addr=100 returns its prior value.
- Back-to-back: cmd_valid held high with 3 queued writes, rsp_ready tied 1 -> one accept per 3 cycles (accept, WR, RSP); mem_we never asserted in two consecutive cycles.

Source files
------------

// File: rtl/bram_thres_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// bram_thres_cfg_ctrl
//
// Host-side configuration sequencer for the per-channel parameter BRAM
// (threshold, channel hash, offset, group number, reference channel banks).
// Accepts write / read / bank-fill commands on a valid/ready command channel,
// drives the BRAM host port, hides the BRAM's 1-cycle registered read and
// returns exactly one response per command on a valid/ready response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                00 write, 01 read, 10 fill bank, 11 reserved
//   cmd_addr, cmd_data    word address (any word of the bank for fill), data
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     read data / 0 for write / DEPTH for fill; error flag
//   busy                  controller not idle
//   err_cnt               saturating count of rejected commands
//   mem_addr/din/we/re    BRAM host port (all registered)
//   mem_dout              BRAM read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module bram_thres_cfg_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 256,
  parameter int BANK_NUM = 5,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [BITWIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BITWIDTH-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BITWIDTH-1:0] mem_din,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [BITWIDTH-1:0] mem_dout
);

  localparam int IDX_W = $clog2(DEPTH) + 1;
  // One bit wider than the address so the limit itself is representable.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(BANK_NUM * DEPTH);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_FILL,
    S_RSP
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BITWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BITWIDTH-1:0] mem_din_q, mem_din_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;

  logic                accept;
  logic                cmd_bad;
  logic [ADDR_W-1:0]   bank_base;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fill_idx_d  = fill_idx_q;
    // BRAM strobes are single-cycle by default; address/data return to 0 so
    // the port is quiet whenever no access is in flight.
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = '0;
    mem_din_d   = '0;

    accept    = cmd_valid & cmd_ready_q;
    cmd_bad   = (cmd_op == OP_RSVD) || ({1'b0, cmd_addr} >= ADDR_LIMIT);
    bank_base = (cmd_addr / ADDR_W'(DEPTH)) * ADDR_W'(DEPTH);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_bad) begin
            // Rejected commands never touch the BRAM.
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            unique case (cmd_op)
              OP_WRITE: begin
                state_d    = S_WR;
                mem_we_d   = 1'b1;
                mem_addr_d = cmd_addr;
                mem_din_d  = cmd_data;
              end
              OP_READ: begin
                state_d    = S_RD;
                mem_re_d   = 1'b1;
                mem_addr_d = cmd_addr;
              end
              default: begin
                // Fill: first write lands on word 0 of the addressed bank.
                state_d    = S_FILL;
                mem_we_d   = 1'b1;
                mem_addr_d = bank_base;
                mem_din_d  = cmd_data;
                fill_idx_d = '0;
              end
            endcase
          end
        end
      end

      S_WR: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
      end

      S_RD: begin
        // BRAM registers the read at the end of this cycle.
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = mem_dout;
      end

      S_FILL: begin
        if (fill_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = BITWIDTH'(DEPTH);
        end else begin
          fill_idx_d = fill_idx_q + IDX_W'(1);
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          mem_din_d  = mem_din_q;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      fill_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_cnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_bram_thres_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_thres_cfg_ctrl
//
// Directed bench for bram_thres_cfg_ctrl. A behavioural BRAM (1-cycle
// registered read, unwritten words read back as 32'hA500_0000 | addr) sits on
// the host port. Stimulus pushes the expected response into a scoreboard
// queue; a negedge monitor pops and compares on every response handshake and
// keeps activity counters for the BRAM port.
// -----------------------------------------------------------------------------
module tb_bram_thres_cfg_ctrl;

  localparam int BITWIDTH = 32;
  localparam int DEPTH    = 256;
  localparam int BANK_NUM = 5;
  localparam int ADDR_W   = 16;
  localparam int WORDS    = BANK_NUM * DEPTH;

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BITWIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [BITWIDTH-1:0] rsp_data;
  logic                rsp_err;
  logic                busy;
  logic [15:0]         err_cnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BITWIDTH-1:0] mem_din;
  logic                mem_we;
  logic                mem_re;
  logic [BITWIDTH-1:0] mem_dout;

  bram_thres_cfg_ctrl #(
    .BITWIDTH(BITWIDTH), .DEPTH(DEPTH), .BANK_NUM(BANK_NUM), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .err_cnt(err_cnt),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural BRAM ----------------
  logic [31:0] bram    [WORDS];
  bit          written [WORDS];

  function automatic logic [31:0] bram_word(input int a);
    return written[a] ? bram[a] : (32'hA500_0000 | 32'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < WORDS) begin
      bram[mem_addr]    <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_dout <= bram_word(int'(mem_addr));
  end

  // ---------------- scoreboard & counters ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   tot = 0;
  int   bad = 0;

  int   cyc = 0;
  int   we_cnt = 0, re_cnt = 0, both_cnt = 0, we_consec = 0;
  int   we_min = 0, we_max = 0, we_last = 0;
  int   acc_cnt = 0, acc_cyc = 0, rsp_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    rsp_t e;
    logic prev_we;
    logic prev_rv;
    prev_we = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we === 1'b1) begin
        we_cnt++;
        if (int'(mem_addr) < we_min) we_min = int'(mem_addr);
        if (int'(mem_addr) > we_max) we_max = int'(mem_addr);
        we_last = int'(mem_addr);
        if (prev_we) we_consec++;
      end
      if (mem_re === 1'b1) re_cnt++;
      if (mem_we === 1'b1 && mem_re === 1'b1) both_cnt++;
      prev_we = (mem_we === 1'b1);
      if (rsp_valid === 1'b1 && !prev_rv) rsp_rise_cyc = cyc;
      prev_rv = (rsp_valid === 1'b1);
      if (cmd_valid && cmd_ready === 1'b1) begin
        acc_cnt++;
        acc_cyc = cyc;
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin : global_guard
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    we_cnt = 0; re_cnt = 0; both_cnt = 0; we_consec = 0;
    we_min = 1 << 30; we_max = -1; we_last = -1;
  endtask

  task automatic send(input logic [1:0] op, input int addr,
                      input logic [31:0] data, input logic [31:0] exp_d,
                      input logic exp_e);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (cmd_ready !== 1'b1) check("send_timeout", 32'd0, 32'd1);
    cmd_op    = op;
    cmd_addr  = ADDR_W'(addr);
    cmd_data  = data;
    cmd_valid = 1'b1;
    sb.push_back('{data: exp_d, err: exp_e});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_flags"}, {27'd0, rsp_valid, rsp_err, busy, mem_we, mem_re}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_mem_addr_din"}, {16'd0, mem_addr} | mem_din, 32'd0);
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int a0;
    int acc_c[3];
    int stall_bad;
    logic [31:0] snap;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) step();
    check_reset("reset");
    rst_n = 1'b1;
    step();
    clr_cnt();

    // 1) write then read addr 3
    send(2'b00, 3, 32'hFFFF_FE0C, 32'd0, 1'b0);
    drain("wr3");
    check("wr3_latency", 32'(rsp_rise_cyc - acc_cyc), 32'd2);
    check("wr3_we_cnt", 32'(we_cnt), 32'd1);
    check("wr3_we_addr", 32'(we_last), 32'd3);
    send(2'b01, 3, 32'd0, 32'hFFFF_FE0C, 1'b0);
    drain("rd3");
    check("rd3_latency", 32'(rsp_rise_cyc - acc_cyc), 32'd3);
    check("rd3_re_cnt", 32'(re_cnt), 32'd1);

    // 2) fill bank 1 via addr 300 with 7
    clr_cnt();
    send(2'b10, 300, 32'd7, 32'd256, 1'b0);
    drain("fill1");
    check("fill1_we_cnt", 32'(we_cnt), 32'd256);
    check("fill1_we_min", 32'(we_min), 32'd256);
    check("fill1_we_max", 32'(we_max), 32'd511);
    send(2'b01, 256, 32'd0, 32'd7, 1'b0);
    send(2'b01, 511, 32'd0, 32'd7, 1'b0);
    send(2'b01, 255, 32'd0, 32'hA500_00FF, 1'b0);
    send(2'b01, 512, 32'd0, 32'hA500_0200, 1'b0);
    drain("fill1_rd");

    // 3) rejected commands: address 1280 and reserved op
    clr_cnt();
    send(2'b01, 1280, 32'd0, 32'd0, 1'b1);
    send(2'b11, 0, 32'h1234, 32'd0, 1'b1);
    drain("err");
    check("err_no_mem", 32'(we_cnt + re_cnt), 32'd0);
    check("err_cnt2", {16'd0, err_cnt}, 32'd2);

    // 4) response back-pressure on read of last legal word
    clr_cnt();
    rsp_ready = 1'b0;
    a0 = acc_cnt;
    send(2'b01, 1279, 32'd0, 32'hA500_04FF, 1'b0);
    step();
    step();
    check("stall_valid", {31'd0, rsp_valid}, 32'd1);
    snap = rsp_data;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_op    = 2'b00;
      cmd_addr  = 16'd5;
      cmd_data  = 32'hDEAD_BEEF;
      cmd_valid = (i % 2 == 0);
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0)
        stall_bad++;
    end
    cmd_valid = 1'b0;
    check("stall_hold", 32'(stall_bad), 32'd0);
    rsp_ready = 1'b1;
    drain("stall");
    check("stall_one_accept", 32'(acc_cnt - a0), 32'd1);
    check("stall_no_we", 32'(we_cnt), 32'd0);
    check("stall_word5", bram_word(5), 32'hA500_0005);

    // 5) reset in the middle of a bank-0 fill
    clr_cnt();
    send(2'b10, 0, 32'd5, 32'd256, 1'b0);
    n = 0;
    while (we_cnt < 100 && n < 1000) begin
      step();
      n++;
    end
    if (we_cnt < 100) check("fill0_timeout", 32'd0, 32'd1);
    check("fill0_idx100_addr", {16'd0, mem_addr}, 32'd100);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    send(2'b01, 99, 32'd0, 32'd5, 1'b0);
    send(2'b01, 100, 32'd0, 32'hA500_0064, 1'b0);
    send(2'b01, 0, 32'd0, 32'd5, 1'b0);
    drain("midrst_rd");

    // 6) back-to-back writes with cmd_valid held high
    clr_cnt();
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_op   = 2'b00;
      cmd_addr = 16'(10 + k);
      cmd_data = 32'(11 * (k + 1));
      sb.push_back('{data: 32'd0, err: 1'b0});
      a0 = acc_cnt;
      n  = 0;
      while (acc_cnt == a0 && n < 50) begin
        step();
        n++;
      end
      if (acc_cnt == a0) check("b2b_accept_timeout", 32'd0, 32'd1);
      acc_c[k] = acc_cyc;
    end
    cmd_valid = 1'b0;
    drain("b2b");
    check("b2b_gap01", 32'(acc_c[1] - acc_c[0]), 32'd3);
    check("b2b_gap12", 32'(acc_c[2] - acc_c[1]), 32'd3);
    check("b2b_we_cnt", 32'(we_cnt), 32'd3);
    check("b2b_we_consec", 32'(we_consec), 32'd0);
    check("b2b_word12", bram_word(12), 32'd33);
    check("never_we_and_re", 32'(both_cnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
